// File: rtl/memory_wishbone_master.sv
// Bridges a simple core-side memory request interface onto a Wishbone classic
// master. One transfer at a time: IDLE accepts a request, BUS runs the
// Wishbone cycle until ack, err or timeout, and DONE presents the result for
// exactly one cycle.
//
// Ports:
//   clk, rst                 clock; asynchronous active-low reset
//   memoryAddress/ByteSelect core request address (byte) and lane enables
//   memoryWriteEnable/ReadEnable, memoryDataWrite   request type and write data
//   memoryDataRead, memoryAccessFault               result, valid in DONE only
//   memoryBusy               transfer pending
//   wb_*                     Wishbone classic master side
module memory_wishbone_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] memoryAddress,
  input  logic [3:0]  memoryByteSelect,
  input  logic        memoryWriteEnable,
  input  logic        memoryReadEnable,
  input  logic [31:0] memoryDataWrite,
  output logic [31:0] memoryDataRead,
  output logic        memoryBusy,
  output logic        memoryAccessFault,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_data_o,
  input  logic [31:0] wb_data_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i
);

  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StBus, StDone} state_e;

  state_e      state_q, state_d;
  logic [29:0] adr_q, adr_d;
  logic [3:0]  sel_q, sel_d;
  logic        we_q, we_d;
  logic [31:0] wdata_q, wdata_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        fault_q, fault_d;

  logic        req;
  logic        illegal;
  logic [31:0] lane_mask;
  logic        in_bus;
  logic        in_done;

  // Word-aligned bus: the byte offset bits are deliberately dropped.
  logic        unused_addr_lsb;
  assign unused_addr_lsb = ^memoryAddress[1:0];

  assign req     = memoryReadEnable | memoryWriteEnable;
  assign illegal = (memoryReadEnable & memoryWriteEnable) | (memoryByteSelect == 4'b0000);
  assign lane_mask = {{8{sel_q[3]}}, {8{sel_q[2]}}, {8{sel_q[1]}}, {8{sel_q[0]}}};

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    sel_d   = sel_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    fault_d = fault_q;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          if (illegal) begin
            // Rejected without touching the bus.
            fault_d = 1'b1;
            rdata_d = '0;
            state_d = StDone;
          end else begin
            adr_d   = memoryAddress[31:2];
            sel_d   = memoryByteSelect;
            we_d    = memoryWriteEnable;
            wdata_d = memoryDataWrite;
            cnt_d   = '0;
            state_d = StBus;
          end
        end
      end
      StBus: begin
        // err takes priority over a simultaneous ack; ack in the last allowed
        // cycle still completes normally.
        if (wb_err_i) begin
          fault_d = 1'b1;
          rdata_d = '0;
          state_d = StDone;
        end else if (wb_ack_i) begin
          fault_d = 1'b0;
          rdata_d = we_q ? 32'h0 : (wb_data_i & lane_mask);
          state_d = StDone;
        end else if (cnt_q == TimeoutLast) begin
          fault_d = 1'b1;
          rdata_d = '0;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      adr_q   <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
    end
  end

  assign in_bus  = (state_q == StBus);
  assign in_done = (state_q == StDone);

  // Reset forces state_q to IDLE asynchronously, so cyc/stb drop at once.
  assign wb_cyc_o  = in_bus;
  assign wb_stb_o  = in_bus;
  assign wb_we_o   = in_bus & we_q;
  assign wb_sel_o  = in_bus ? sel_q : 4'b0000;
  assign wb_adr_o  = in_bus ? {adr_q, 2'b00} : 32'h0;
  assign wb_data_o = in_bus ? wdata_q : 32'h0;

  assign memoryBusy        = in_bus | ((state_q == StIdle) & req);
  assign memoryDataRead    = in_done ? rdata_q : 32'h0;
  assign memoryAccessFault = in_done & fault_q;

endmodule

// File: tb/tb_memory_wishbone_master.sv
// Directed bench for memory_wishbone_master. Each transaction is described by
// its request and the slave's response; the expected per-cycle outputs follow
// from the transfer timeline (request cycle, N bus cycles, one result cycle).
module tb_memory_wishbone_master;

  localparam int unsigned T = 4;

  logic        clk;
  logic        rst;
  logic [31:0] memoryAddress;
  logic [3:0]  memoryByteSelect;
  logic        memoryWriteEnable;
  logic        memoryReadEnable;
  logic [31:0] memoryDataWrite;
  logic [31:0] memoryDataRead;
  logic        memoryBusy;
  logic        memoryAccessFault;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_data_o;
  logic [31:0] wb_data_i;
  logic        wb_ack_i;
  logic        wb_err_i;

  memory_wishbone_master #(.TIMEOUT_CYCLES(T)) dut (
    .clk               (clk),
    .rst               (rst),
    .memoryAddress     (memoryAddress),
    .memoryByteSelect  (memoryByteSelect),
    .memoryWriteEnable (memoryWriteEnable),
    .memoryReadEnable  (memoryReadEnable),
    .memoryDataWrite   (memoryDataWrite),
    .memoryDataRead    (memoryDataRead),
    .memoryBusy        (memoryBusy),
    .memoryAccessFault (memoryAccessFault),
    .wb_cyc_o          (wb_cyc_o),
    .wb_stb_o          (wb_stb_o),
    .wb_we_o           (wb_we_o),
    .wb_sel_o          (wb_sel_o),
    .wb_adr_o          (wb_adr_o),
    .wb_data_o         (wb_data_o),
    .wb_data_i         (wb_data_i),
    .wb_ack_i          (wb_ack_i),
    .wb_err_i          (wb_err_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Expected outputs for the current cycle.
  logic        exp_valid = 1'b0;
  logic        exp_cyc, exp_busy, exp_fault, exp_bus, exp_done, exp_we;
  logic [31:0] exp_dread, exp_adr, exp_wdata;
  logic [3:0]  exp_sel;

  // Observations summarised per transaction.
  int          obs_bus_cycles;
  int          obs_busy_cycles;
  logic [31:0] obs_data;
  logic        obs_fault;
  logic [31:0] obs_adr;
  logic        obs_we;
  logic [31:0] obs_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] lanes(input logic [3:0] s);
    logic [31:0] m;
    m = '0;
    for (int b = 0; b < 4; b++) if (s[b]) m[b*8 +: 8] = 8'hFF;
    return m;
  endfunction

  // Single compare process: checks the DUT against the expectations each cycle.
  always @(negedge clk) begin
    if (exp_valid) begin
      chk("cyc", {31'b0, wb_cyc_o}, {31'b0, exp_cyc});
      chk("stb", {31'b0, wb_stb_o}, {31'b0, exp_cyc});
      chk("busy", {31'b0, memoryBusy}, {31'b0, exp_busy});
      chk("dread", memoryDataRead, exp_dread);
      chk("fault", {31'b0, memoryAccessFault}, {31'b0, exp_fault});
      if (exp_bus) begin
        chk("we", {31'b0, wb_we_o}, {31'b0, exp_we});
        chk("sel", {28'b0, wb_sel_o}, {28'b0, exp_sel});
        chk("adr", wb_adr_o, exp_adr);
        chk("wdata", wb_data_o, exp_wdata);
      end
      if (wb_cyc_o) begin
        obs_bus_cycles++;
        obs_adr   = wb_adr_o;
        obs_we    = wb_we_o;
        obs_wdata = wb_data_o;
      end
      if (memoryBusy) obs_busy_cycles++;
      if (exp_done) begin
        obs_data  = memoryDataRead;
        obs_fault = memoryAccessFault;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_exp(input logic cyc, input logic busy, input logic done,
                         input logic [31:0] dread, input logic fault);
    exp_valid = 1'b1;
    exp_cyc   = cyc;
    exp_bus   = cyc;
    exp_busy  = busy;
    exp_done  = done;
    exp_dread = dread;
    exp_fault = fault;
  endtask

  // kind: 0 ack, 1 err, 2 ack+err, 3 no response. resp is the 1-based bus cycle.
  task automatic txn(input logic we, input logic re, input logic [31:0] addr,
                     input logic [3:0] sel, input logic [31:0] wdata,
                     input int resp, input int kind, input logic [31:0] rdata);
    logic        illegal;
    logic        fault;
    logic [31:0] data;
    int          n;
    obs_bus_cycles  = 0;
    obs_busy_cycles = 0;
    obs_data  = 32'hFFFF_FFFF;
    obs_fault = 1'bx;
    obs_adr   = 32'hFFFF_FFFF;
    obs_we    = 1'bx;
    obs_wdata = 32'hFFFF_FFFF;
    illegal = (we && re) || (sel == 4'b0000);
    // Request cycle.
    step();
    memoryAddress = addr; memoryByteSelect = sel; memoryWriteEnable = we;
    memoryReadEnable = re; memoryDataWrite = wdata;
    wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_data_i = 32'hDEAD_BEEF;
    set_exp(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    if (illegal) begin
      fault = 1'b1;
      data  = 32'h0;
    end else begin
      n     = (kind == 3) ? int'(T) : ((resp < int'(T)) ? resp : int'(T));
      fault = (kind != 0) || (n < resp) || (kind == 3);
      data  = (fault || we) ? 32'h0 : (rdata & lanes(sel));
      exp_we = we; exp_sel = sel; exp_adr = {addr[31:2], 2'b00}; exp_wdata = wdata;
      for (int i = 1; i <= n; i++) begin
        step();
        // Request inputs wander during the bus cycle; they must be ignored.
        memoryAddress = ~addr; memoryByteSelect = ~sel; memoryWriteEnable = ~we;
        memoryReadEnable = ~re; memoryDataWrite = ~wdata;
        wb_ack_i  = (i == resp) && (kind == 0 || kind == 2);
        wb_err_i  = (i == resp) && (kind == 1 || kind == 2);
        wb_data_i = (i == resp) ? rdata : 32'hDEAD_BEEF;
        set_exp(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
      end
    end
    // Result cycle; a request presented here must be ignored.
    step();
    memoryAddress = 32'h0000_0500; memoryByteSelect = 4'hF; memoryWriteEnable = 1'b0;
    memoryReadEnable = 1'b1; memoryDataWrite = 32'h0;
    wb_ack_i = 1'b1; wb_err_i = 1'b0; wb_data_i = 32'h0BAD_0BAD;
    set_exp(1'b0, 1'b0, 1'b1, data, fault);
    // Quiet idle cycle.
    step();
    memoryReadEnable = 1'b0; memoryByteSelect = 4'h0; memoryAddress = 32'h0;
    wb_ack_i = 1'b0; wb_data_i = 32'h0;
    set_exp(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cyc"}, {31'b0, wb_cyc_o}, 32'h0);
    chk({tag, "_stb"}, {31'b0, wb_stb_o}, 32'h0);
    chk({tag, "_we"}, {31'b0, wb_we_o}, 32'h0);
    chk({tag, "_sel"}, {28'b0, wb_sel_o}, 32'h0);
    chk({tag, "_adr"}, wb_adr_o, 32'h0);
    chk({tag, "_wdata"}, wb_data_o, 32'h0);
    chk({tag, "_dread"}, memoryDataRead, 32'h0);
    chk({tag, "_fault"}, {31'b0, memoryAccessFault}, 32'h0);
  endtask

  initial begin
    rst = 1'b0;
    memoryAddress = '0; memoryByteSelect = '0; memoryWriteEnable = 1'b0;
    memoryReadEnable = 1'b0; memoryDataWrite = '0;
    wb_data_i = '0; wb_ack_i = 1'b0; wb_err_i = 1'b0;
    #2;
    chk_all_zero("reset");
    chk("reset_busy", {31'b0, memoryBusy}, 32'h0);
    #10 rst = 1'b1;

    // Read, ack in 2nd bus cycle.
    txn(1'b0, 1'b1, 32'h0000_1006, 4'b1100, 32'h0, 2, 0, 32'hAABB_CCDD);
    chk("read_adr", obs_adr, 32'h0000_1004);
    chk("read_busy_cycles", obs_busy_cycles, 3);
    chk("read_data", obs_data, 32'hAABB_0000);
    chk("read_fault", {31'b0, obs_fault}, 32'h0);

    // Write, immediate ack.
    txn(1'b1, 1'b0, 32'h0000_0020, 4'b1111, 32'h1234_5678, 1, 0, 32'h9999_9999);
    chk("write_we", {31'b0, obs_we}, 32'h1);
    chk("write_wdata", obs_wdata, 32'h1234_5678);
    chk("write_busy_cycles", obs_busy_cycles, 2);
    chk("write_fault", {31'b0, obs_fault}, 32'h0);
    chk("write_data", obs_data, 32'h0);

    // err and ack together: err wins.
    txn(1'b0, 1'b1, 32'h0000_0040, 4'b1111, 32'h0, 1, 2, 32'h55AA_55AA);
    chk("err_fault", {31'b0, obs_fault}, 32'h1);
    chk("err_data", obs_data, 32'h0);

    // Silent slave: timeout after T bus cycles.
    txn(1'b0, 1'b1, 32'h0000_0080, 4'b0011, 32'h0, 0, 3, 32'h0);
    chk("tmo_bus_cycles", obs_bus_cycles, 4);
    chk("tmo_fault", {31'b0, obs_fault}, 32'h1);

    // Ack in the last allowed cycle still succeeds.
    txn(1'b0, 1'b1, 32'h0000_00C0, 4'b1111, 32'h0, 4, 0, 32'h0102_0304);
    chk("lastack_data", obs_data, 32'h0102_0304);
    chk("lastack_fault", {31'b0, obs_fault}, 32'h0);

    // Illegal requests.
    txn(1'b1, 1'b1, 32'h0000_0100, 4'b1111, 32'h0, 1, 0, 32'h0);
    chk("ill_both_bus", obs_bus_cycles, 0);
    chk("ill_both_fault", {31'b0, obs_fault}, 32'h1);
    txn(1'b0, 1'b1, 32'h0000_0104, 4'b0000, 32'h0, 1, 0, 32'h0);
    chk("ill_sel_bus", obs_bus_cycles, 0);
    chk("ill_sel_busy_cycles", obs_busy_cycles, 1);

    // Sparse lanes, high address, ack in 3rd cycle.
    txn(1'b0, 1'b1, 32'hFFFF_FFFF, 4'b0101, 32'h0, 3, 0, 32'h1122_3344);
    chk("sparse_data", obs_data, 32'h0022_0044);
    chk("sparse_adr", obs_adr, 32'hFFFF_FFFC);

    // Plain error response on a write.
    txn(1'b1, 1'b0, 32'h0000_0210, 4'b0110, 32'hCAFE_BABE, 2, 1, 32'h0);
    chk("werr_fault", {31'b0, obs_fault}, 32'h1);

    // Reset in the middle of a bus cycle.
    exp_valid = 1'b0;
    step();
    memoryAddress = 32'h0000_0200; memoryByteSelect = 4'hF; memoryReadEnable = 1'b1;
    step();
    memoryReadEnable = 1'b0;
    step();
    chk("mid_cyc_before", {31'b0, wb_cyc_o}, 32'h1);
    #2 rst = 1'b0;
    #1;
    chk_all_zero("midrst");
    chk("midrst_busy", {31'b0, memoryBusy}, 32'h0);
    memoryReadEnable = 1'b1;
    #1;
    chk("midrst_busy_req", {31'b0, memoryBusy}, 32'h1);
    chk("midrst_cyc_req", {31'b0, wb_cyc_o}, 32'h0);
    memoryReadEnable = 1'b0; memoryByteSelect = 4'h0;
    @(negedge clk);
    rst = 1'b1;
    txn(1'b0, 1'b1, 32'h0000_0300, 4'b1111, 32'h0, 1, 0, 32'hCAFE_F00D);
    chk("post_rst_data", obs_data, 32'hCAFE_F00D);
    chk("post_rst_fault", {31'b0, obs_fault}, 32'h0);

    exp_valid = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
